// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI master / SPI slave / RAM subsystem:
// master FSM states and the 2-bit command codes carried in frame[9:8].
package spi_ram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SEND,
        WAIT,
        RECV,
        DONE
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_master_ram_if.sv
// Host-side SPI master for the SPI-slave/RAM subsystem; SPI bit clock is clk itself.
// Optional macro SPI_MASTER_REQ_ERR_EN adds req_err, flagging requests dropped while busy.
module spi_master_ram_if
    import spi_ram_pkg::*;
#(
    parameter int FRAME_W   = 10,
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 2,
    parameter int RD_WAIT   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [FRAME_W-1:0] req_frame,
    output logic               req_ready,
    output logic               ss_n,
    output logic               MOSI,
    input  logic               MISO,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid,
    output logic               busy
`ifdef SPI_MASTER_REQ_ERR_EN
    ,
    output logic               req_err
`endif
);

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max_int(max_int(SETUP_CYC, FRAME_W), max_int(RD_WAIT, DATA_W));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [FRAME_W-1:0] tx_sh;
    logic [DATA_W-2:0]  rx_sh;
    logic               rd_frame;

    // Counter holds "cycles left in this state minus one"; it is reloaded on every state entry.
    function automatic logic [CNT_W-1:0] load_cnt(input state_t s);
        case (s)
            SETUP:   return CNT_W'(SETUP_CYC - 1);
            SEND:    return CNT_W'(FRAME_W - 1);
            WAIT:    return CNT_W'(RD_WAIT - 1);
            RECV:    return CNT_W'(DATA_W - 1);
            default: return '0;
        endcase
    endfunction

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_valid) state_n = SETUP;
            SETUP:   if (cnt == '0) state_n = SEND;
            SEND:    if (cnt == '0) state_n = rd_frame ? WAIT : DONE;
            WAIT:    if (cnt == '0) state_n = RECV;
            RECV:    if (cnt == '0) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (state_n != state) begin
            cnt_n = load_cnt(state_n);
        end else if (cnt != '0) begin
            cnt_n = cnt - CNT_W'(1);
        end else begin
            cnt_n = cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rd_frame <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rd_valid <= (state == RECV) && (cnt == '0);
            if (state == IDLE && req_valid) begin
                tx_sh    <= req_frame;
                rd_frame <= (req_frame[FRAME_W-1 -: 2] == CMD_RD_DATA);
            end
            if (state == SEND) begin
                tx_sh <= {tx_sh[FRAME_W-2:0], 1'b0};
            end
            // MISO is sampled at the edge closing each RECV cycle; the last sample lands in rd_data directly.
            if (state == RECV) begin
                rx_sh <= {rx_sh[DATA_W-3:0], MISO};
                if (cnt == '0) rd_data <= {rx_sh, MISO};
            end
        end
    end

`ifdef SPI_MASTER_REQ_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) req_err <= 1'b0;
        else     req_err <= req_valid && (state != IDLE);
    end
`endif

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign ss_n      = (state == IDLE) || (state == DONE);
    assign MOSI      = (state == SEND) ? tx_sh[FRAME_W-1] : 1'b0;

endmodule
